// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams the conjugated steering matrix out of the Hermitian result BRAM as valid/ready samples.
// Define CONJ_OUT_EN to negate (with saturation) the stored imaginary part, yielding the original matrix.
module bram_stream_reader #(
   parameter int DATA_WIDTH         = 24,
   parameter int BRAM_RD_ADDR_WIDTH = 15,
   parameter int BRAM_RD_INCREASE   = 4,
   parameter int BASE_ADDR          = 0,
   parameter int LATENCY            = 2,
   parameter int MIC_NUM            = 8,
   parameter int SOR_NUM            = 2,
   parameter int FREQ_NUM           = 257,
   parameter int FIFO_DEPTH         = LATENCY + 2,
   localparam int TOTAL_NUM         = MIC_NUM * SOR_NUM * FREQ_NUM,
   localparam int CNT_WIDTH         = $clog2(TOTAL_NUM)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic [BRAM_RD_ADDR_WIDTH-1:0] bram_rd_addr,
   output logic                          bram_rd_en,
   input  logic [DATA_WIDTH-1:0]         bram_rd_real,
   input  logic [DATA_WIDTH-1:0]         bram_rd_imag,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_WIDTH-1:0]         m_real,
   output logic [DATA_WIDTH-1:0]         m_imag,
   output logic [CNT_WIDTH-1:0]          m_idx,
   output logic                          m_last,
   output logic                          busy,
   output logic                          done
);
   localparam int AW = BRAM_RD_ADDR_WIDTH;
   localparam int RW = $clog2(TOTAL_NUM + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam longint ADDR_END = longint'(BASE_ADDR) + longint'(TOTAL_NUM - 1) * longint'(BRAM_RD_INCREASE);

   if (ADDR_END >= (longint'(1) << BRAM_RD_ADDR_WIDTH)) begin : g_addr_range
      $error("bram_stream_reader: last element address exceeds BRAM_RD_ADDR_WIDTH");
   end
   if (FIFO_DEPTH < LATENCY + 1) begin : g_fifo_depth
      $error("bram_stream_reader: FIFO_DEPTH must be at least LATENCY+1");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state;
   logic [RW-1:0]         rd_cnt;
   logic [AW-1:0]         addr_q;
   logic [LATENCY-1:0]    pipe;
   logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_i [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [FW-1:0]         fifo_count;
   logic [CNT_WIDTH-1:0]  out_cnt;
   logic [DATA_WIDTH-1:0] push_imag;
   logic                  push, pop, issue, active;
   int                    inflight;

   // reads still owed to the FIFO: the one on the BRAM port plus those in the latency pipe
   always_comb begin
      inflight = int'(bram_rd_en);
      for (int k = 0; k < LATENCY; k++) inflight += int'(pipe[k]);
   end

`ifdef CONJ_OUT_EN
   localparam logic [DATA_WIDTH-1:0] NEG_MAX = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   assign push_imag = (bram_rd_imag == NEG_MAX) ? ~NEG_MAX : -bram_rd_imag;
`else
   assign push_imag = bram_rd_imag;
`endif

   assign active  = (state == RUN) || (state == IDLE && start);
   assign push    = pipe[LATENCY-1];
   assign m_valid = fifo_count != '0;
   assign pop     = m_valid && m_ready;
   // a slot freed by this cycle's pop is reusable at once, so one sample per cycle is sustained
   assign issue   = active && rd_cnt < RW'(TOTAL_NUM)
                    && int'(fifo_count) - int'(pop) + inflight < FIFO_DEPTH;
   assign m_real  = m_valid ? mem_r[rd_ptr] : '0;
   assign m_imag  = m_valid ? mem_i[rd_ptr] : '0;
   assign m_idx   = out_cnt;
   assign m_last  = m_valid && out_cnt == CNT_WIDTH'(TOTAL_NUM - 1);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr] <= bram_rd_real;
         mem_i[wr_ptr] <= push_imag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rd_cnt       <= '0;
         addr_q       <= AW'(BASE_ADDR);
         bram_rd_addr <= '0;
         bram_rd_en   <= 1'b0;
         pipe         <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         out_cnt      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         bram_rd_en <= issue;
         pipe       <= LATENCY'({pipe, bram_rd_en});
         done       <= 1'b0;
         fifo_count <= fifo_count + FW'(push) - FW'(pop);
         if (issue) begin
            bram_rd_addr <= addr_q;
            addr_q       <= addr_q + AW'(BRAM_RD_INCREASE);
            rd_cnt       <= rd_cnt + 1'b1;
         end
         if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            out_cnt <= out_cnt + 1'b1;
         end
         case (state)
            IDLE: if (start) begin
               state <= RUN;
               busy  <= 1'b1;
            end
            RUN, DRAIN: if (pop && m_last) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else if (state == RUN && rd_cnt == RW'(TOTAL_NUM)) begin
               state <= DRAIN;
            end
            default: begin
               state   <= IDLE;
               rd_cnt  <= '0;
               addr_q  <= AW'(BASE_ADDR);
               out_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) assert (fifo_count < FW'(FIFO_DEPTH) || pop)
         else $error("bram_stream_reader: FIFO overflow");
   end
endmodule
